// File: rtl/axi_hp_write_arbiter.sv
// Two-requester AXI3 write arbiter onto a single HP port.
// Per-burst round-robin grant; B responses are routed by the top bit of the response ID.
module axi_hp_write_arbiter #(
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic [AXI_ID_WIDTH-1:0]     s0_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [3:0]                  s0_axi_awlen,
    input  logic [2:0]                  s0_axi_awsize,
    input  logic [1:0]                  s0_axi_awburst,
    input  logic [3:0]                  s0_axi_awcache,
    input  logic                        s0_axi_awvalid,
    output logic                        s0_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s0_axi_wid,
    input  logic [AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                        s0_axi_wlast,
    input  logic                        s0_axi_wvalid,
    output logic                        s0_axi_wready,
    output logic                        s0_axi_bvalid,
    input  logic                        s0_axi_bready,

    input  logic [AXI_ID_WIDTH-1:0]     s1_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [3:0]                  s1_axi_awlen,
    input  logic [2:0]                  s1_axi_awsize,
    input  logic [1:0]                  s1_axi_awburst,
    input  logic [3:0]                  s1_axi_awcache,
    input  logic                        s1_axi_awvalid,
    output logic                        s1_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s1_axi_wid,
    input  logic [AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                        s1_axi_wlast,
    input  logic                        s1_axi_wvalid,
    output logic                        s1_axi_wready,
    output logic                        s1_axi_bvalid,
    input  logic                        s1_axi_bready,

    output logic [AXI_ID_WIDTH:0]       m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [3:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic [3:0]                  m_axi_awcache,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ID_WIDTH:0]       m_axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH:0]       m_axi_bid,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,

    output logic [63:0]                 sts_data
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  beat_q, beat_d;
    logic [3:0]  len_q, len_d;
    logic [15:0] bursts0_q, bursts0_d;
    logic [15:0] bursts1_q, bursts1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;

    logic in_addr, in_data, aw_hs, w_hs, b_sel;
    logic unused_bid;

    // Gating with aresetn keeps every handshake output low while reset is held.
    assign in_addr = aresetn && (state_q == StAddr);
    assign in_data = aresetn && (state_q == StData);

    assign m_axi_awid    = grant_q ? {1'b1, s1_axi_awid} : {1'b0, s0_axi_awid};
    assign m_axi_awaddr  = grant_q ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m_axi_awlen   = grant_q ? s1_axi_awlen   : s0_axi_awlen;
    assign m_axi_awsize  = grant_q ? s1_axi_awsize  : s0_axi_awsize;
    assign m_axi_awburst = grant_q ? s1_axi_awburst : s0_axi_awburst;
    assign m_axi_awcache = grant_q ? s1_axi_awcache : s0_axi_awcache;
    assign m_axi_awvalid = in_addr && (grant_q ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = in_addr && !grant_q && m_axi_awready;
    assign s1_axi_awready = in_addr &&  grant_q && m_axi_awready;

    assign m_axi_wid    = grant_q ? {1'b1, s1_axi_wid} : {1'b0, s0_axi_wid};
    assign m_axi_wdata  = grant_q ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb  = grant_q ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wlast  = grant_q ? s1_axi_wlast : s0_axi_wlast;
    assign m_axi_wvalid = in_data && (grant_q ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready = in_data && !grant_q && m_axi_wready;
    assign s1_axi_wready = in_data &&  grant_q && m_axi_wready;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    // B path is independent of the burst FSM; the ID top bit names the requester.
    assign b_sel         = m_axi_bid[AXI_ID_WIDTH];
    assign s0_axi_bvalid = aresetn && m_axi_bvalid && !b_sel;
    assign s1_axi_bvalid = aresetn && m_axi_bvalid &&  b_sel;
    assign m_axi_bready  = aresetn && (b_sel ? s1_axi_bready : s0_axi_bready);
    assign unused_bid    = ^m_axi_bid[AXI_ID_WIDTH-1:0];

    assign sts_data = {err0_q, err1_q, 30'b0, bursts1_q, bursts0_q};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        len_d        = len_q;
        bursts0_d    = bursts0_q;
        bursts1_d    = bursts1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        unique case (state_q)
            StIdle: begin
                if (s0_axi_awvalid || s1_axi_awvalid) begin
                    grant_d = (s0_axi_awvalid && s1_axi_awvalid) ? !last_grant_q : s1_axi_awvalid;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (aw_hs) begin
                    len_d   = m_axi_awlen;
                    beat_d  = 4'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    beat_d = beat_q + 4'd1;
                    // wlast must coincide exactly with the beat numbered awlen.
                    if (m_axi_wlast != (beat_q == len_q)) begin
                        if (grant_q) err1_d = 1'b1;
                        else         err0_d = 1'b1;
                    end
                    if (m_axi_wlast) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                        if (grant_q) bursts1_d = bursts1_q + 16'd1;
                        else         bursts0_d = bursts0_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= 4'd0;
            len_q        <= 4'd0;
            bursts0_q    <= 16'd0;
            bursts1_q    <= 16'd0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            bursts0_q    <= bursts0_d;
            bursts1_q    <= bursts1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

endmodule

// File: tb/tb_axi_hp_write_arbiter.sv
// Bench for axi_hp_write_arbiter: bench-side requesters and downstream slave, checked
// every cycle against a transaction-level model of grant, forwarding, counters and errors.
module tb_axi_hp_write_arbiter;
    localparam int IW = 6;
    localparam int AW = 32;
    localparam int DW = 64;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [IW-1:0]   s_awid[2];
    logic [AW-1:0]   s_awaddr[2];
    logic [3:0]      s_awlen[2];
    logic [2:0]      s_awsize[2];
    logic [1:0]      s_awburst[2];
    logic [3:0]      s_awcache[2];
    logic            s_awvalid[2], s_awready[2];
    logic [IW-1:0]   s_wid[2];
    logic [DW-1:0]   s_wdata[2];
    logic [DW/8-1:0] s_wstrb[2];
    logic            s_wlast[2], s_wvalid[2], s_wready[2];
    logic            s_bvalid[2], s_bready[2];

    logic [IW:0]     m_awid, m_wid, m_bid;
    logic [AW-1:0]   m_awaddr;
    logic [3:0]      m_awlen, m_awcache;
    logic [2:0]      m_awsize;
    logic [1:0]      m_awburst;
    logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_bvalid, m_bready;
    logic [63:0]     sts;

    axi_hp_write_arbiter #(.AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axi_awid(s_awid[0]), .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]),
        .s0_axi_awsize(s_awsize[0]), .s0_axi_awburst(s_awburst[0]),
        .s0_axi_awcache(s_awcache[0]), .s0_axi_awvalid(s_awvalid[0]),
        .s0_axi_awready(s_awready[0]), .s0_axi_wid(s_wid[0]), .s0_axi_wdata(s_wdata[0]),
        .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wlast(s_wlast[0]), .s0_axi_wvalid(s_wvalid[0]),
        .s0_axi_wready(s_wready[0]), .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]),
        .s1_axi_awid(s_awid[1]), .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]),
        .s1_axi_awsize(s_awsize[1]), .s1_axi_awburst(s_awburst[1]),
        .s1_axi_awcache(s_awcache[1]), .s1_axi_awvalid(s_awvalid[1]),
        .s1_axi_awready(s_awready[1]), .s1_axi_wid(s_wid[1]), .s1_axi_wdata(s_wdata[1]),
        .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wlast(s_wlast[1]), .s1_axi_wvalid(s_wvalid[1]),
        .s1_axi_wready(s_wready[1]), .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]),
        .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
        .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awcache(m_awcache),
        .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_wid(m_wid),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bid(m_bid),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .sts_data(sts)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        int            last_idx;
        int            gap;
    } burst_t;

    int tests = 0;
    int fails = 0;

    burst_t bq[2][16];
    int head[2], cnt[2], rphase[2], rbeat[2], rgap[2], exp_b[2];
    bit exp_err[2];
    int owner, last_win, cyc, obs_beats, exp_beats;
    bit aw_done;
    int order[$];
    int wr_mode, aw_rand, wv_rand, b_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(int p, int k);
        return {bq[p][head[p] % 16].addr, 20'h0, 4'(p), 4'(head[p]), 4'(k)};
    endfunction

    task automatic model_reset();
        owner = -1; aw_done = 0; last_win = 1; order.delete();
        obs_beats = 0; exp_beats = 0;
        for (int p = 0; p < 2; p++) begin
            head[p] = 0; cnt[p] = 0; rphase[p] = 0; rbeat[p] = 0; rgap[p] = 0;
            exp_b[p] = 0; exp_err[p] = 0;
        end
    endtask

    task automatic add_burst(int p, int len, int last_idx, int gap);
        bq[p][cnt[p]] = '{id: IW'($urandom), addr: {$urandom} & 32'hffff_fff8, len: 4'(len),
                          last_idx: last_idx, gap: gap};
        exp_beats += last_idx + 1;
        cnt[p]++;
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            burst_t b;
            b = bq[p][head[p] % 16];
            s_awvalid[p] = (rphase[p] == 1);
            s_awid[p] = b.id; s_awaddr[p] = b.addr; s_awlen[p] = b.len;
            s_awsize[p] = 3'(3 - p); s_awburst[p] = 2'b01; s_awcache[p] = 4'(3 + p);
            s_wvalid[p] = (rphase[p] == 2) && (wv_rand == 0 || $urandom_range(0, 2) != 0);
            s_wid[p] = b.id; s_wdata[p] = beat_data(p, rbeat[p]);
            s_wstrb[p] = 8'hff ^ 8'(rbeat[p]); s_wlast[p] = (rbeat[p] == b.last_idx);
            s_bready[p] = 1'($urandom_range(0, 1));
        end
        m_awready = (aw_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        m_wready = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        m_bvalid = (b_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        m_bid = (b_mode != 0) ? {1'b1, IW'($urandom)} : (IW + 1)'($urandom);
    endtask

    task automatic check();
        bit awv, wv;
        burst_t b;
        awv = (owner >= 0) && !aw_done;
        wv = (owner >= 0) ? (aw_done && s_wvalid[owner]) : 1'b0;
        chk("m_awvalid", m_awvalid, awv);
        if (awv) begin
            b = bq[owner][head[owner] % 16];
            chk("m_awid", m_awid, {owner[0], b.id});
            chk("m_awaddr", m_awaddr, b.addr);
            chk("m_awlen", m_awlen, b.len);
            chk("m_awsize", m_awsize, 3'(3 - owner));
            chk("m_awcache", m_awcache, 4'(3 + owner));
        end
        chk("m_wvalid", m_wvalid, wv);
        if (wv) begin
            b = bq[owner][head[owner] % 16];
            chk("m_wid", m_wid, {owner[0], b.id});
            chk("m_wdata", m_wdata, beat_data(owner, rbeat[owner]));
            chk("m_wstrb", m_wstrb, 8'hff ^ 8'(rbeat[owner]));
            chk("m_wlast", m_wlast, rbeat[owner] == b.last_idx);
        end
        for (int p = 0; p < 2; p++) begin
            chk("s_awready", s_awready[p], awv && owner == p && m_awready);
            chk("s_wready", s_wready[p], owner == p && aw_done && m_wready);
        end
        chk("s0_bvalid", s_bvalid[0], m_bvalid && !m_bid[IW]);
        chk("s1_bvalid", s_bvalid[1], m_bvalid && m_bid[IW]);
        chk("m_bready", m_bready, m_bid[IW] ? s_bready[1] : s_bready[0]);
        chk("sts_data", sts, {exp_err[0], exp_err[1], 30'b0, 16'(exp_b[1]), 16'(exp_b[0])});
        if (m_wvalid && m_wready) obs_beats++;
    endtask

    task automatic update();
        if (owner < 0) begin
            if (s_awvalid[0] || s_awvalid[1]) begin
                owner = (s_awvalid[0] && s_awvalid[1]) ? 1 - last_win : (s_awvalid[1] ? 1 : 0);
                aw_done = 0;
                order.push_back(owner);
            end
        end else if (!aw_done) begin
            if (m_awready) begin
                aw_done = 1; rphase[owner] = 2; rbeat[owner] = 0;
            end
        end else if (s_wvalid[owner] && m_wready) begin
            int p;
            bit lst;
            burst_t b;
            p = owner;
            b = bq[p][head[p] % 16];
            lst = (rbeat[p] == b.last_idx);
            if (lst != (rbeat[p] == int'(b.len))) exp_err[p] = 1;
            rbeat[p]++;
            if (lst) begin
                exp_b[p] = (exp_b[p] + 1) % 65536;
                last_win = p; owner = -1; head[p]++;
                rgap[p] = b.gap; rphase[p] = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rphase[p] == 0 && head[p] < cnt[p]) begin
                if (rgap[p] > 0) rgap[p]--;
                else rphase[p] = 1;
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        check();
        update();
        @(posedge aclk);
        @(negedge aclk);
        cyc++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awrdy"}, {s_awready[1], s_awready[0]}, 2'b00);
        chk({tag, "_wrdy"}, {s_wready[1], s_wready[0]}, 2'b00);
        chk({tag, "_mvalid"}, {m_awvalid, m_wvalid}, 2'b00);
        chk({tag, "_bvalid"}, {s_bvalid[1], s_bvalid[0]}, 2'b00);
        chk({tag, "_bready"}, m_bready, 1'b0);
        chk({tag, "_sts"}, sts, 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        model_reset();
        drive();
        @(posedge aclk);
        @(negedge aclk);
        drive();
        #1;
        chk_quiet("reset");
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic run(input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
            done = (owner < 0) && head[0] >= cnt[0] && head[1] >= cnt[1];
        end
        chk("drained", done, 1'b1);
        cycle();
        chk("beat_count", obs_beats, exp_beats);
    endtask

    initial begin
        int t;
        cyc = 0; wr_mode = 0; aw_rand = 0; wv_rand = 0; b_mode = 0;
        model_reset();
        @(negedge aclk);

        // Single requester, 16-beat burst, everything ready.
        do_reset();
        add_burst(0, 15, 15, 0);
        run(200);
        chk("single_bursts0", sts[15:0], 16'd1);

        // Simultaneous requests: strict alternation starting with port 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            add_burst(0, $urandom_range(0, 15), 0, 0);
            bq[0][i].last_idx = int'(bq[0][i].len);
            add_burst(1, $urandom_range(0, 15), 0, 0);
            bq[1][i].last_idx = int'(bq[1][i].len);
        end
        exp_beats = 0;
        for (int i = 0; i < 3; i++) exp_beats += int'(bq[0][i].len) + int'(bq[1][i].len) + 2;
        run(500);
        chk("tie_order_n", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++) chk("tie_order", order[i], i % 2);
        chk("tie_bursts", sts[31:0], {16'd3, 16'd3});

        // Downstream wready toggling each cycle.
        do_reset();
        wr_mode = 1;
        add_burst(0, 9, 9, 1);
        add_burst(1, 6, 6, 0);
        add_burst(0, 15, 15, 0);
        run(500);

        // Early wlast from port 1 sets only err1.
        do_reset();
        wr_mode = 0;
        add_burst(1, 15, 7, 0);
        add_burst(0, 3, 3, 0);
        run(200);
        chk("err1_set", sts[62], 1'b1);
        chk("err0_clear", sts[63], 1'b0);

        // Forced B response to port 1 while port 0 owns the data phase.
        do_reset();
        b_mode = 1;
        add_burst(0, 7, 7, 0);
        run(200);
        b_mode = 0;

        // Randomised traffic with throttling, gaps and occasional bad wlast.
        do_reset();
        wr_mode = 2; aw_rand = 1; wv_rand = 1;
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < 2; p++) begin
                int len;
                len = $urandom_range(0, 15);
                add_burst(p, len, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len,
                          $urandom_range(0, 3));
            end
        end
        run(4000);

        // Reset in the middle of a port 0 burst.
        do_reset();
        wr_mode = 0; aw_rand = 0; wv_rand = 0; b_mode = 1;
        add_burst(0, 15, 15, 0);
        t = 0;
        while (!(owner == 0 && aw_done && rbeat[0] == 6) && t < 100) begin
            cycle();
            t++;
        end
        chk("reached_beat5", rbeat[0], 6);
        aresetn = 1'b0;
        drive();
        @(posedge aclk);
        @(negedge aclk);
        drive();
        #1;
        chk_quiet("midrst");
        @(posedge aclk);
        @(negedge aclk);
        b_mode = 0;
        model_reset();
        aresetn = 1'b1;
        add_burst(0, 2, 2, 0);
        add_burst(1, 2, 2, 0);
        run(200);
        chk("post_rst_tie", order.size() > 0 ? order[0] : -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_hp_write_arbiter.md
AXI_HP_WRITE_ARBITER -- requirements
Module: axi_hp_write_arbiter

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 6, upstream write ID width; downstream ID width is AXI_ID_WIDTH+1.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, write address width.
REQ-003 Parameter AXI_DATA_WIDTH, default 64, write data width; strobe width AXI_DATA_WIDTH/8.
REQ-004 aclk  input  1  clock; all logic on rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 sN_axi_aw{id,addr,len,size,burst,cache,valid}  input  AXI3 widths (len 4, size 3, burst 2, cache 4)  write address from requester N, N=0,1.
REQ-007 sN_axi_awready  output  1  address accepted from requester N.
REQ-008 sN_axi_w{id,data,strb,last,valid}  input  AXI3 widths  write data from requester N.
REQ-009 sN_axi_wready  output  1  data beat accepted from requester N.
REQ-010 sN_axi_bvalid  output  1  write response to requester N; sN_axi_bready input 1.
REQ-011 m_axi_aw*/m_axi_w*  output (awready, wready input)  same fields; m_axi_awid/m_axi_wid AXI_ID_WIDTH+1 bits  shared HP port.
REQ-012 m_axi_bid  input  AXI_ID_WIDTH+1; m_axi_bvalid input 1; m_axi_bready output 1.
REQ-013 sts_data  output  64  {err0, err1, 30'b0, bursts1[15:0], bursts0[15:0]}.

Function
REQ-014 Arbitration SHALL be per burst with a three-state FSM: IDLE, ADDR, DATA; register grant (1 bit), register last_grant (1 bit).
REQ-015 IDLE: if exactly one sN_axi_awvalid high, grant := N; if both high, grant := ~last_grant; go to ADDR next cycle; else stay IDLE.
REQ-016 ADDR: m_axi_aw* SHALL mirror the granted port combinationally, m_axi_awid = {grant, s_awid}; sN_axi_awready = m_axi_awready for granted port only; on m_axi_awvalid & m_axi_awready go to DATA.
REQ-017 DATA: m_axi_w* SHALL mirror the granted port, m_axi_wid = {grant, s_wid}; granted sN_axi_wready = m_axi_wready; on beat handshake with wlast go to IDLE and set last_grant := grant.
REQ-018 Non-granted port, and any port outside its phase, SHALL see awready=0 and wready=0; m_axi_awvalid=0 outside ADDR, m_axi_wvalid=0 outside DATA.
REQ-019 Latency: m_axi_awvalid SHALL rise exactly one cycle after sN_axi_awvalid is seen in IDLE; back-to-back bursts incur one IDLE cycle each.
REQ-020 B channel SHALL route independently of FSM: sN_axi_bvalid = m_axi_bvalid & (m_axi_bid[MSB]==N); m_axi_bready = bready of port selected by m_axi_bid[MSB].
REQ-021 A 4-bit beat counter SHALL count W handshakes in DATA, cleared on entry to DATA; wlast on beat index != awlen of the burst, or beat index == awlen without wlast, SHALL set sticky errN for the granted port; FSM still leaves DATA only on wlast.
REQ-022 burstsN SHALL increment by 1 on each completed burst of port N (wlast handshake), wrapping at 16 bits.
REQ-023 Arbiter SHALL not reorder or buffer beats; throughput is limited only by downstream ready.

Reset
REQ-024 On aresetn=0: FSM IDLE, grant 0, last_grant 1 (port 0 wins first tie), beat counter 0, counters 0, err bits 0.
REQ-025 Reset outputs: all awready, wready, m_axi_awvalid, m_axi_wvalid, sN_axi_bvalid 0; m_axi_bready 0.
REQ-026 Reset mid-burst SHALL abandon the burst immediately; upstream requesters are reset in the same domain.

Verification
REQ-027 Only s0 requests, awlen 15, ready always 1 -> m_awvalid 1 cycle later, m_awid={0,id}, 16 beats pass, bursts0=1.
REQ-028 s0 and s1 awvalid same cycle after reset, 3 bursts each -> grant order 0,1,0,1,0,1; bursts0=bursts1=3.
REQ-029 m_axi_wready toggles 1/0 during DATA -> every beat forwarded exactly once, no beat on non-granted port, wlast closes burst.
REQ-030 s1 asserts wlast on beat 7 of awlen 15 -> err1=1 sticky, FSM returns IDLE, err0 stays 0.
REQ-031 m_axi_bvalid with bid MSB=1 while s0 burst in DATA -> s1_bvalid=1, s0_bvalid=0, m_bready = s1_bready.
REQ-032 aresetn low at beat 5 of s0 burst -> next cycle all valids/readies 0, sts_data 0, port 0 wins next tie.
